// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and the serial engine state encoding.
package mmio_uart_pkg;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;
  localparam logic [3:0] ADDR_CTRL    = 4'hC;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;
  localparam int unsigned CNT_DISP_W = 4;

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DEFAULT_BAUD_DIV = 16'd868;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push into a full FIFO is
// still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU data-port UART transmitter: bus register file, TX FIFO and an 8N1
// serial engine that shifts bytes out LSB first.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH  = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_i,
  input  logic [3:0]  we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] div_m1_c;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             en_q;
  logic             ovf_q;
  logic [31:0]      rdata_q;

  logic             push_c;
  logic             pop_c;
  logic             start_c;
  logic [7:0]       head_c;
  logic             full_c;
  logic             empty_c;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       word_addr_c;
  logic [CNT_DISP_W-1:0] cnt_disp_c;
  logic [31:0]      status_c;
  logic [31:0]      rd_mux_c;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

  assign word_addr_c = {addr_i[3:2], 2'b00};
  assign push_c      = sel_i && we_i[0] && (word_addr_c == ADDR_TXDATA);
  assign div_m1_c    = (div_q == '0) ? '0 : div_q - DIV_W'(1);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .din     (wdata_i[7:0]),
    .pop     (pop_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (fifo_count)
  );

  // Occupancy shown in a fixed 4-bit field, saturating for deep FIFOs.
  assign cnt_disp_c = (32'(fifo_count) > 32'd15) ? 4'hF : CNT_DISP_W'(fifo_count);

  always_comb begin
    status_c = '0;
    status_c[ST_FULL]  = full_c;
    status_c[ST_EMPTY] = empty_c;
    status_c[ST_BUSY]  = (state_q != S_IDLE);
    status_c[ST_OVF]   = ovf_q;
    status_c[ST_CNT_LSB +: CNT_DISP_W] = cnt_disp_c;
  end

  always_comb begin
    rd_mux_c = '0;
    case (word_addr_c)
      ADDR_STATUS:  rd_mux_c = status_c;
      ADDR_BAUDDIV: rd_mux_c = {16'h0000, div_q};
      ADDR_CTRL:    rd_mux_c = {31'h0, en_q};
      default:      rd_mux_c = '0;
    endcase
  end

  // Bus register file; reads capture pre-update values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= DEFAULT_DIV;
      en_q    <= 1'b1;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (sel_i && (we_i == 4'b0000)) rdata_q <= rd_mux_c;
      if (sel_i && (we_i != 4'b0000)) begin
        case (word_addr_c)
          ADDR_STATUS:  if (we_i[0] && wdata_i[ST_OVF]) ovf_q <= 1'b0;
          ADDR_BAUDDIV: begin
            if (we_i[0]) div_q[7:0]  <= wdata_i[7:0];
            if (we_i[1]) div_q[15:8] <= wdata_i[15:8];
          end
          ADDR_CTRL:    if (we_i[0]) en_q <= wdata_i[0];
          default:      ;
        endcase
      end
      if (push_c && full_c && !pop_c) ovf_q <= 1'b1;
    end
  end

  // Serial engine next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop_c    = 1'b0;
    start_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        start_c = 1'b1;
      end
      S_START: begin
        if (timer_q == '0) begin
          state_d = S_DATA;
          timer_d = period_q;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (timer_q == '0) begin
          timer_d = period_q;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          start_c = 1'b1;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Frame start: latch the divider so mid-frame writes wait for the next frame.
    if (start_c && en_q && !empty_c) begin
      pop_c    = 1'b1;
      state_d  = S_START;
      shift_d  = head_c;
      period_d = div_m1_c;
      timer_d  = div_m1_c;
      idx_d    = 3'd0;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign rdata_o = rdata_q;
  assign tx_o    = tx_q;
  assign irq_o   = empty_c && (state_q == S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: table-driven register accesses plus
// hand-written serial-frame and reset sequences.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel_i = 1'b0;
  logic [3:0]  we_i = 4'h0;
  logic [3:0]  addr_i = 4'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        tx_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sel_i   (sel_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .tx_o    (tx_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the commit edge.
  task automatic bus_write(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
    sel_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    @(negedge clk);
    sel_i = 1'b0; we_i = 4'h0; wdata_i = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel_i = 1'b1; we_i = 4'h0; addr_i = a;
    @(negedge clk);
    sel_i = 1'b0;
    d = rdata_o;
  endtask

  // Compares tx_o/irq_o sample-by-sample against an 8N1 model of the bytes.
  task automatic check_frames(input string tag, input int nbytes, input logic [7:0] b0,
                              input logic [7:0] b1, input int period, input bit first_now);
    logic exp_bits[$];
    logic [7:0] b;
    for (int f = 0; f < nbytes; f++) begin
      b = (f == 0) ? b0 : b1;
      for (int p = 0; p < period; p++) exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int p = 0; p < period; p++) exp_bits.push_back(b[i]);
      for (int p = 0; p < period; p++) exp_bits.push_back(1'b1);
    end
    for (int k = 0; k < exp_bits.size(); k++) begin
      if (!(k == 0 && first_now)) @(negedge clk);
      check($sformatf("%s tx[%0d]", tag, k), {31'h0, tx_o}, {31'h0, exp_bits[k]});
      check($sformatf("%s irq[%0d]", tag, k), {31'h0, irq_o}, 32'h0);
    end
    @(negedge clk);
    check($sformatf("%s idle tx", tag), {31'h0, tx_o}, 32'h1);
    check($sformatf("%s idle irq", tag), {31'h0, irq_o}, 32'h1);
  endtask

  initial begin
    logic [31:0] r;
    bit saw_low;

    // Reset state while held in reset.
    repeat (3) @(negedge clk);
    check("rst rdata", rdata_o, 32'h0);
    check("rst tx", {31'h0, tx_o}, 32'h1);
    check("rst irq", {31'h0, irq_o}, 32'h1);
    reset = 1'b1;
    @(negedge clk);

    // Register-level vectors.
    tbl.push_back('{1'b0, 4'h4, 4'h0, 32'h0, 32'h0000_0002});
    tbl.push_back('{1'b0, 4'h8, 4'h0, 32'h0, 32'h0000_0364});
    tbl.push_back('{1'b0, 4'hC, 4'h0, 32'h0, 32'h0000_0001});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 4'h0, 4'b0010, 32'h0000_7777, 32'h0});
    tbl.push_back('{1'b0, 4'h4, 4'h0, 32'h0, 32'h0000_0002});
    tbl.push_back('{1'b0, 4'h5, 4'h0, 32'h0, 32'h0000_0002});
    tbl.push_back('{1'b1, 4'h8, 4'b0001, 32'h0000_00FF, 32'h0});
    tbl.push_back('{1'b0, 4'h8, 4'h0, 32'h0, 32'h0000_03FF});
    tbl.push_back('{1'b1, 4'h8, 4'b0011, 32'h0000_0004, 32'h0});
    tbl.push_back('{1'b0, 4'h8, 4'h0, 32'h0, 32'h0000_0004});
    tbl.push_back('{1'b1, 4'hC, 4'b0001, 32'h0000_0000, 32'h0});
    tbl.push_back('{1'b0, 4'hC, 4'h0, 32'h0, 32'h0000_0000});
    for (int i = 0; i < 9; i++)
      tbl.push_back('{1'b1, 4'h0, 4'b0001, 32'h0000_0010 + 32'(i), 32'h0});
    tbl.push_back('{1'b0, 4'h4, 4'h0, 32'h0, 32'h0000_0809});
    tbl.push_back('{1'b1, 4'h4, 4'b0001, 32'h0000_0008, 32'h0});
    tbl.push_back('{1'b0, 4'h4, 4'h0, 32'h0, 32'h0000_0801});
    tbl.push_back('{1'b1, 4'h8, 4'b0011, 32'h0000_0001, 32'h0});
    tbl.push_back('{1'b1, 4'hC, 4'b0001, 32'h0000_0001, 32'h0});

    foreach (tbl[i]) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].we, tbl[i].wdata);
      else begin
        bus_read(tbl[i].addr, r);
        check($sformatf("vec%0d", i), r, tbl[i].exp);
      end
    end

    // Eight queued bytes drain at one clock per bit.
    repeat (100) @(negedge clk);
    bus_read(4'h4, r);
    check("drained status", r, 32'h0000_0002);

    // 0x55 at four clocks per bit.
    bus_write(4'h8, 4'b0011, 32'h4);
    bus_write(4'h0, 4'b0001, 32'h55);
    check_frames("f55", 1, 8'h55, 8'h00, 4, 1'b0);

    // Back-to-back bytes: second start bit follows the first stop bit directly.
    bus_write(4'h8, 4'b0011, 32'h2);
    sel_i = 1'b1; we_i = 4'b0001; addr_i = 4'h0; wdata_i = 32'hA0;
    @(negedge clk);
    wdata_i = 32'h0F;
    @(negedge clk);
    sel_i = 1'b0; we_i = 4'h0; wdata_i = 32'h0;
    check_frames("b2b", 2, 8'hA0, 8'h0F, 2, 1'b1);

    // A divider of zero behaves as one clock per bit.
    bus_write(4'h8, 4'b0011, 32'h0);
    bus_write(4'h0, 4'b0001, 32'h01);
    check_frames("div0", 1, 8'h01, 8'h00, 1, 1'b0);

    // Reset asserted in the middle of a frame.
    bus_write(4'h8, 4'b0011, 32'h4);
    bus_write(4'h0, 4'b0001, 32'h00);
    bus_read(4'h4, r);
    check("pre-pop status", r, 32'h0000_0100);
    bus_read(4'h4, r);
    check("busy status", r, 32'h0000_0006);
    repeat (12) @(negedge clk);
    check("mid-frame tx", {31'h0, tx_o}, 32'h0);
    #1 reset = 1'b0;
    #1;
    check("async rst tx", {31'h0, tx_o}, 32'h1);
    check("async rst irq", {31'h0, irq_o}, 32'h1);
    check("async rst rdata", rdata_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(4'h4, r);
    check("post-rst status", r, 32'h0000_0002);
    bus_read(4'h8, r);
    check("post-rst baud", r, 32'h0000_0364);
    saw_low = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_o !== 1'b1) saw_low = 1'b1;
    end
    check("no partial frame", {31'h0, saw_low}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
